// File: rtl/de1_color_seq_pkg.sv
// de1_color_seq_pkg: shared types and constants for the color sequencer.
// Register map, CTRL bit positions, FSM states and palette helpers.
package de1_color_seq_pkg;

    localparam int COLOR_W   = 4;
    localparam int N_ENTRIES = 8;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_DWELL   = 3'd1;
    localparam logic [2:0] REG_LAST    = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_PALETTE = 3'd4;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_OS_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DWELL
    } state_e;

    function automatic logic [COLOR_W-1:0] pal_entry(
        input logic [N_ENTRIES*COLOR_W-1:0] pal,
        input logic [2:0]                   i
    );
        return pal[{i, 2'b00} +: COLOR_W];
    endfunction

endpackage

// File: rtl/de1_color_seq_regs.sv
// de1_color_seq_regs: host-facing config register file and read mux.
// The host write to CTRL takes priority over the sequencer's enable clear.
module de1_color_seq_regs
    import de1_color_seq_pkg::*;
#(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address_i,
    input  logic               chipselect_i,
    input  logic               write_n_i,
    input  logic [31:0]        writedata_i,
    input  logic               clr_enable_i,
    input  logic               busy_i,
    input  logic [2:0]         idx_i,
    input  logic [3:0]         cur_color_i,
    output logic [31:0]        readdata_o,
    output logic               enable_o,
    output logic               one_shot_o,
    output logic [DWELL_W-1:0] dwell_o,
    output logic [2:0]         last_o,
    output logic [31:0]        palette_o
);

    logic               en_q;
    logic               os_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [2:0]         last_q;
    logic [31:0]        pal_q;
    logic               wr_d;

    assign wr_d = chipselect_i && !write_n_i;

    // Config writes; a same-edge host write overrides the end-of-run clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= 1'b0;
            os_q    <= 1'b0;
            dwell_q <= '0;
            last_q  <= '0;
            pal_q   <= '0;
        end else begin
            if (clr_enable_i) en_q <= 1'b0;
            if (wr_d) begin
                case (address_i)
                    REG_CTRL: begin
                        en_q <= writedata_i[CTRL_EN_BIT];
                        os_q <= writedata_i[CTRL_OS_BIT];
                    end
                    REG_DWELL:   dwell_q <= writedata_i[DWELL_W-1:0];
                    REG_LAST:    last_q  <= writedata_i[2:0];
                    REG_PALETTE: pal_q   <= writedata_i;
                    default: ;
                endcase
            end
        end
    end

    // Combinational read mux, unmapped addresses read as zero
    always_comb begin
        readdata_o = '0;
        case (address_i)
            REG_CTRL:    readdata_o = {30'd0, os_q, en_q};
            REG_DWELL:   readdata_o = 32'(dwell_q);
            REG_LAST:    readdata_o = {29'd0, last_q};
            REG_STATUS:  readdata_o = {20'd0, cur_color_i, 1'b0,
                                       idx_i, 3'd0, busy_i};
            REG_PALETTE: readdata_o = pal_q;
            default:     readdata_o = '0;
        endcase
    end

    assign enable_o   = en_q;
    assign one_shot_o = os_q;
    assign dwell_o    = dwell_q;
    assign last_o     = last_q;
    assign palette_o  = pal_q;

endmodule

// File: rtl/de1_color_sequencer.sv
// de1_color_sequencer: Avalon-MM palette sequencer for the VGA color PIO.
// Steps a packed palette with a programmable dwell, one master write per step.
module de1_color_sequencer
    import de1_color_seq_pkg::*;
#(
    parameter int         DWELL_W     = 24,
    parameter logic [1:0] TARGET_ADDR = 2'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic [3:0]  cur_color,
    output logic        done_irq
);

    logic               enable;
    logic               one_shot;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         last;
    logic [31:0]        palette;

    state_e             state_q;
    logic [2:0]         idx_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [3:0]         cur_q;
    logic [3:0]         m_data_q;
    logic               m_cs_q;
    logic               m_wn_q;
    logic               irq_q;

    logic               at_end_d;
    logic [2:0]         idx_d;
    logic [DWELL_W-1:0] reload_d;
    logic               clr_en_d;

    de1_color_seq_regs #(
        .DWELL_W (DWELL_W)
    ) u_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .address_i    (address),
        .chipselect_i (chipselect),
        .write_n_i    (write_n),
        .writedata_i  (writedata),
        .clr_enable_i (clr_en_d),
        .busy_i       (state_q != ST_IDLE),
        .idx_i        (idx_q),
        .cur_color_i  (cur_q),
        .readdata_o   (readdata),
        .enable_o     (enable),
        .one_shot_o   (one_shot),
        .dwell_o      (dwell),
        .last_o       (last),
        .palette_o    (palette)
    );

    // Treat an index past a lowered LAST as the end of the palette
    assign at_end_d = (idx_q >= last);
    assign idx_d    = at_end_d ? 3'd0 : idx_q + 3'd1;
    assign reload_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign clr_en_d = (state_q == ST_DWELL) && enable &&
                      (cnt_q == '0) && at_end_d && one_shot;

    // Sequencer FSM with registered master-port outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            cur_q    <= '0;
            m_data_q <= '0;
            m_cs_q   <= 1'b0;
            m_wn_q   <= 1'b1;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q  <= ST_WRITE;
                        idx_q    <= 3'd0;
                        m_data_q <= pal_entry(palette, 3'd0);
                        m_cs_q   <= 1'b1;
                        m_wn_q   <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (!m_waitrequest) begin
                        cur_q   <= m_data_q;
                        m_cs_q  <= 1'b0;
                        m_wn_q  <= 1'b1;
                        cnt_q   <= reload_d;
                        state_q <= enable ? ST_DWELL : ST_IDLE;
                    end
                end
                ST_DWELL: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (at_end_d && one_shot) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b1;
                    end else begin
                        state_q  <= ST_WRITE;
                        idx_q    <= idx_d;
                        m_data_q <= pal_entry(palette, idx_d);
                        m_cs_q   <= 1'b1;
                        m_wn_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_address    = TARGET_ADDR;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = m_wn_q;
    assign m_writedata  = {28'd0, m_data_q};
    assign cur_color    = cur_q;
    assign done_irq     = irq_q;

endmodule

// File: tb/tb_de1_color_sequencer.sv
// tb_de1_color_sequencer: directed and randomized checks of the sequencer.
// Expected writes come from a schedule model: accept k at E+2+k*(max(D,1)+1).
module tb_de1_color_sequencer;
    import de1_color_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic [3:0]  cur_color;
    logic        done_irq;

    de1_color_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .cur_color     (cur_color),
        .done_irq      (done_irq)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         acc_t[$];
    logic [3:0] acc_d[$];
    int         irq_cnt = 0;
    int         total = 0;
    int         bad = 0;
    int         last_wr_edge = 0;

    // Edge counter plus log of accepted master writes and irq cycles
    always @(posedge clk) begin
        if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
            acc_t.push_back(cyc);
            acc_d.push_back(m_writedata[3:0]);
        end
        if (done_irq) irq_cnt++;
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_color(input logic [31:0] pal,
                                             input int k, input int lst);
        logic [31:0] s;
        s = pal >> (4 * (k % (lst + 1)));
        return s[3:0];
    endfunction

    task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect   = 1'b0;
        write_n      = 1'b1;
        last_wr_edge = cyc - 1;
    endtask

    task automatic run_seq(input logic [31:0] pal, input int lst,
                           input int dw, input int nk);
        int p;
        int e;
        int a;
        p = ((dw == 0) ? 1 : dw) + 1;
        host_wr(REG_DWELL, 32'(dw));
        host_wr(REG_LAST, 32'(lst));
        host_wr(REG_PALETTE, pal);
        acc_t.delete();
        acc_d.delete();
        host_wr(REG_CTRL, 32'h1);
        e = last_wr_edge;
        address = REG_STATUS;
        for (int k = 0; k < nk; k++) begin
            a = e + 2 + k * p;
            while (cyc < a) @(negedge clk);
            chk("seq_strobe", 32'({m_chipselect, m_write_n}), 32'h2);
            chk("seq_maddr", 32'(m_address), 32'h0);
            chk("seq_wdata", m_writedata, 32'(exp_color(pal, k, lst)));
            @(negedge clk);
            chk("seq_acc_cnt", 32'(acc_t.size()), 32'(k + 1));
            if (acc_t.size() > k) chk("seq_acc_time", 32'(acc_t[k]), 32'(a));
            chk("seq_status", readdata,
                {20'd0, exp_color(pal, k, lst), 1'b0,
                 3'(k % (lst + 1)), 3'd0, 1'b1});
        end
        host_wr(REG_CTRL, 32'h0);
        repeat (p + 2) @(negedge clk);
        address = REG_STATUS;
        #1 chk("seq_idle", 32'(readdata[0]), 32'h0);
    endtask

    initial begin
        logic [31:0] pal;
        logic [31:0] npal;
        logic [31:0] rexp;
        int          d;
        int          p;
        int          e;
        int          x;
        int          l;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_wn", 32'(m_write_n), 32'h1);
        chk("rst_cs", 32'(m_chipselect), 32'h0);
        chk("rst_irq", 32'(done_irq), 32'h0);
        chk("rst_color", 32'(cur_color), 32'h0);
        address = REG_STATUS;
        #1 chk("rst_status", readdata, 32'h0);

        // palette 1,2,5 with dwell 3: one write every 4 cycles
        run_seq(32'h0000_0521, 2, 3, 6);

        // randomized palettes, lengths and dwell times
        for (int r = 0; r < 4; r++) begin
            pal = $urandom;
            l   = int'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 5));
            run_seq(pal, l, d, l + 3);
        end

        // one-shot run of 7 then A
        d = int'($urandom_range(1, 4));
        p = d + 1;
        host_wr(REG_DWELL, 32'(d));
        host_wr(REG_LAST, 32'h1);
        host_wr(REG_PALETTE, 32'h0000_00A7);
        acc_t.delete();
        acc_d.delete();
        irq_cnt = 0;
        host_wr(REG_CTRL, 32'h3);
        e = last_wr_edge;
        while (cyc < e + 2 + p + d + 1) @(negedge clk);
        chk("os_irq_hi", 32'(done_irq), 32'h1);
        @(negedge clk);
        chk("os_irq_lo", 32'(done_irq), 32'h0);
        repeat (10) @(negedge clk);
        chk("os_count", 32'(acc_t.size()), 32'h2);
        if (acc_t.size() == 2) begin
            chk("os_d0", 32'(acc_d[0]), 32'h7);
            chk("os_d1", 32'(acc_d[1]), 32'hA);
            chk("os_t1", 32'(acc_t[1]), 32'(e + 2 + p));
        end
        chk("os_irq_cnt", 32'(irq_cnt), 32'h1);
        address = REG_CTRL;
        #1 chk("os_ctrl", readdata, 32'h2);
        address = REG_STATUS;
        #1 chk("os_busy", 32'(readdata[0]), 32'h0);

        // stall the first write, rewrite palette while held
        pal  = $urandom;
        npal = $urandom;
        d    = int'($urandom_range(1, 4));
        p    = d + 1;
        m_waitrequest = 1'b1;
        host_wr(REG_DWELL, 32'(d));
        host_wr(REG_LAST, 32'h1);
        host_wr(REG_PALETTE, pal);
        acc_t.delete();
        acc_d.delete();
        host_wr(REG_CTRL, 32'h1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_strobe", 32'({m_chipselect, m_write_n}), 32'h2);
            chk("stall_data", m_writedata, 32'(exp_color(pal, 0, 1)));
        end
        host_wr(REG_PALETTE, npal);
        chk("stall_hold", m_writedata, 32'(exp_color(pal, 0, 1)));
        chk("stall_noacc", 32'(acc_t.size()), 32'h0);
        m_waitrequest = 1'b0;
        x = cyc;
        @(negedge clk);
        chk("stall_acc_one", 32'(acc_t.size()), 32'h1);
        if (acc_t.size() == 1) chk("stall_acc_t", 32'(acc_t[0]), 32'(x));
        chk("stall_cur", 32'(cur_color), 32'(exp_color(pal, 0, 1)));
        chk("stall_release", 32'(m_write_n), 32'h1);
        while (cyc < x + p) @(negedge clk);
        chk("stall_next", m_writedata, 32'(exp_color(npal, 1, 1)));
        @(negedge clk);
        chk("stall_next_cnt", 32'(acc_t.size()), 32'h2);
        if (acc_t.size() == 2) chk("stall_next_t", 32'(acc_t[1]), 32'(x + p));
        host_wr(REG_CTRL, 32'h0);
        repeat (8) @(negedge clk);

        // disable while a write is stalled: it still completes
        pal = $urandom;
        m_waitrequest = 1'b1;
        host_wr(REG_DWELL, 32'h1);
        host_wr(REG_LAST, 32'h2);
        host_wr(REG_PALETTE, pal);
        acc_t.delete();
        acc_d.delete();
        host_wr(REG_CTRL, 32'h1);
        @(negedge clk);
        host_wr(REG_CTRL, 32'h0);
        @(negedge clk);
        chk("abort_held", 32'({m_chipselect, m_write_n}), 32'h2);
        m_waitrequest = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_count", 32'(acc_t.size()), 32'h1);
        if (acc_t.size() == 1)
            chk("abort_data", 32'(acc_d[0]), 32'(exp_color(pal, 0, 2)));
        chk("abort_cur", 32'(cur_color), 32'(exp_color(pal, 0, 2)));
        chk("abort_wn", 32'(m_write_n), 32'h1);
        address = REG_STATUS;
        #1 chk("abort_busy", 32'(readdata[0]), 32'h0);

        // dwell 0 single entry, then reset mid-write
        run_seq(32'h0000_000F, 0, 0, 5);
        host_wr(REG_CTRL, 32'h1);
        for (int i = 0; i < 10 && m_write_n; i++) @(negedge clk);
        chk("prerst_wn", 32'(m_write_n), 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_wn", 32'(m_write_n), 32'h1);
        chk("arst_cs", 32'(m_chipselect), 32'h0);
        chk("arst_data", m_writedata, 32'h0);
        chk("arst_cur", 32'(cur_color), 32'h0);
        chk("arst_irq", 32'(done_irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // register readback, including ignored writes
        pal = $urandom;
        d   = int'($urandom_range(0, 32'hFF_FFFF));
        l   = int'($urandom_range(0, 7));
        host_wr(REG_CTRL, 32'h2);
        host_wr(REG_DWELL, 32'(d));
        host_wr(REG_LAST, 32'(l));
        host_wr(REG_PALETTE, pal);
        host_wr(REG_STATUS, 32'hFFFF_FFFF);
        host_wr(3'd5, 32'hFFFF_FFFF);
        for (int a = 0; a < 8; a++) begin
            case (a)
                0:       rexp = 32'h2;
                1:       rexp = 32'(d);
                2:       rexp = 32'(l);
                4:       rexp = pal;
                default: rexp = 32'h0;
            endcase
            address = 3'(a);
            #1 chk($sformatf("rd_addr%0d", a), readdata, rexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
